// File: rtl/control_fsm_gen2.sv
// Second-generation control FSM: Init/Fetch/Decode/Execute sequencing for the
// single-cycle datapath, with jumps, a variable load latency, Run-resume and sticky illegal-opcode flag.
module control_fsm_gen2 #(
  parameter int OP_W    = 4,
  parameter int RA_W    = 4,
  parameter int DA_W    = 8,
  parameter int PA_W    = 8,
  parameter int ALU_W   = 3,
  parameter int MEM_LAT = 1,
  parameter int IR_W    = OP_W + DA_W + RA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [IR_W-1:0]   IR,
  input  logic              Zero,
  input  logic              Run,
  output logic              PC_clr,
  output logic              PC_up,
  output logic              PC_ld,
  output logic [PA_W-1:0]   PC_addr,
  output logic              IR_ld,
  output logic [DA_W-1:0]   D_addr,
  output logic              D_wr,
  output logic              RF_s,
  output logic              RF_W_en,
  output logic [RA_W-1:0]   RF_W_addr,
  output logic [RA_W-1:0]   RF_Ra_addr,
  output logic [RA_W-1:0]   RF_Rb_addr,
  output logic [ALU_W-1:0]  Alu_s0,
  output logic              Halted,
  output logic              Illegal,
  output logic [3:0]        CurrentState,
  output logic [3:0]        NextState
);

  localparam int L     = IR_W - OP_W;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  localparam logic [3:0] S_INIT   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_NOOP   = 4'd3;
  localparam logic [3:0] S_STORE  = 4'd4;
  localparam logic [3:0] S_LOADA  = 4'd5;
  localparam logic [3:0] S_LOADB  = 4'd6;
  localparam logic [3:0] S_ALU    = 4'd7;
  localparam logic [3:0] S_JMP    = 4'd8;
  localparam logic [3:0] S_JZ     = 4'd9;
  localparam logic [3:0] S_HALT   = 4'd10;

  localparam logic [OP_W-1:0] OP_NOOP  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JZ    = OP_W'(7);

  logic [OP_W-1:0]  opcode;
  logic [CNT_W-1:0] wait_cnt;
  logic             bad_opcode;

  assign opcode = IR[IR_W-1 -: OP_W];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) CurrentState <= S_INIT;
    else       CurrentState <= NextState;
  end

  // The counter is armed on the Decode->LoadA transition so LoadA lasts MEM_LAT cycles.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      wait_cnt <= '0;
    else if (CurrentState == S_DECODE && NextState == S_LOADA)
      wait_cnt <= CNT_W'(MEM_LAT - 1);
    else if (CurrentState == S_LOADA && wait_cnt != '0)
      wait_cnt <= wait_cnt - CNT_W'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                       Illegal <= 1'b0;
    else if (CurrentState == S_DECODE && bad_opcode) Illegal <= 1'b1;
  end

  always_comb begin
    NextState  = S_INIT;
    bad_opcode = 1'b0;
    case (CurrentState)
      S_INIT:   NextState = S_FETCH;
      S_FETCH:  NextState = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOOP:        NextState = S_NOOP;
          OP_STORE:       NextState = S_STORE;
          OP_LOAD:        NextState = S_LOADA;
          OP_ADD, OP_SUB: NextState = S_ALU;
          OP_HALT:        NextState = S_HALT;
          OP_JMP:         NextState = S_JMP;
          OP_JZ:          NextState = S_JZ;
          default: begin
            NextState  = S_HALT;
            bad_opcode = 1'b1;
          end
        endcase
      end
      S_NOOP:   NextState = S_FETCH;
      S_STORE:  NextState = S_FETCH;
      S_LOADA:  NextState = (wait_cnt == '0) ? S_LOADB : S_LOADA;
      S_LOADB:  NextState = S_FETCH;
      S_ALU:    NextState = S_FETCH;
      S_JMP:    NextState = S_FETCH;
      S_JZ:     NextState = S_FETCH;
      S_HALT:   NextState = Run ? S_FETCH : S_HALT;
      default:  NextState = S_INIT;
    endcase
  end

  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    PC_ld      = 1'b0;
    PC_addr    = '0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_addr  = '0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    Alu_s0     = '0;
    Halted     = 1'b0;
    case (CurrentState)
      S_INIT:  PC_clr = 1'b1;
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      S_STORE: begin
        D_addr     = IR[DA_W-1:0];
        D_wr       = 1'b1;
        RF_Ra_addr = IR[L-1 -: RA_W];
      end
      S_LOADA, S_LOADB: begin
        D_addr    = IR[L-1 -: DA_W];
        RF_s      = 1'b1;
        RF_W_addr = IR[RA_W-1:0];
        RF_W_en   = (CurrentState == S_LOADB);
      end
      S_ALU: begin
        RF_Ra_addr = IR[L-1 -: RA_W];
        RF_Rb_addr = IR[L-RA_W-1 -: RA_W];
        RF_W_addr  = IR[RA_W-1:0];
        RF_W_en    = 1'b1;
        if (opcode == OP_ADD)      Alu_s0 = ALU_W'(1);
        else if (opcode == OP_SUB) Alu_s0 = ALU_W'(2);
      end
      S_JMP: begin
        PC_ld   = 1'b1;
        PC_addr = IR[PA_W-1:0];
      end
      S_JZ: begin
        PC_ld   = Zero;
        PC_addr = IR[PA_W-1:0];
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_fsm_gen2.sv
// Directed bench for control_fsm_gen2 (MEM_LAT=3): each scenario task checks
// states and decoded outputs against hand-computed values.
module tb_control_fsm_gen2;

  localparam logic [3:0] ST_INIT   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_NOOP   = 4'd3;
  localparam logic [3:0] ST_STORE  = 4'd4;
  localparam logic [3:0] ST_LOADA  = 4'd5;
  localparam logic [3:0] ST_LOADB  = 4'd6;
  localparam logic [3:0] ST_ALU    = 4'd7;
  localparam logic [3:0] ST_JMP    = 4'd8;
  localparam logic [3:0] ST_JZ     = 4'd9;
  localparam logic [3:0] ST_HALT   = 4'd10;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir;
  logic        zero;
  logic        run;
  logic        pc_clr, pc_up, pc_ld, ir_ld, d_wr, rf_s, rf_w_en, halted, illegal;
  logic [7:0]  pc_addr, d_addr;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr;
  logic [2:0]  alu_s0;
  logic [3:0]  cur_state, nxt_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_fsm_gen2 #(.MEM_LAT(3)) dut (
    .Clk(clk), .Reset(reset), .IR(ir), .Zero(zero), .Run(run),
    .PC_clr(pc_clr), .PC_up(pc_up), .PC_ld(pc_ld), .PC_addr(pc_addr),
    .IR_ld(ir_ld), .D_addr(d_addr), .D_wr(d_wr), .RF_s(rf_s),
    .RF_W_en(rf_w_en), .RF_W_addr(rf_w_addr), .RF_Ra_addr(rf_ra_addr),
    .RF_Rb_addr(rf_rb_addr), .Alu_s0(alu_s0), .Halted(halted),
    .Illegal(illegal), .CurrentState(cur_state), .NextState(nxt_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, then walk Fetch and Decode with the given instruction.
  task automatic go_to_exec(input logic [15:0] instr);
    ir = instr;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic test_reset();
    ir = 16'h0000; zero = 1'b0; run = 1'b0; reset = 1'b1;
    #2;
    n_checks++;
    if ({cur_state, pc_clr, pc_up, pc_ld, ir_ld, d_wr, rf_w_en, halted, illegal} !== {ST_INIT, 8'b1000_0000}) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got state=%0d flags=%b, expected state=0 flags=10000000",
               cur_state, {pc_clr, pc_up, pc_ld, ir_ld, d_wr, rf_w_en, halted, illegal});
    end
    step();
    reset = 1'b0;
    n_checks++;
    if (cur_state !== ST_INIT || pc_clr !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL init_after_release: got state=%0d pc_clr=%b, expected 0/1", cur_state, pc_clr);
    end
    step();
    n_checks++;
    if (cur_state !== ST_FETCH || ir_ld !== 1'b1 || pc_up !== 1'b1 || pc_clr !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL fetch: got state=%0d ir_ld=%b pc_up=%b pc_clr=%b, expected 1/1/1/0",
               cur_state, ir_ld, pc_up, pc_clr);
    end
    step();
    n_checks++;
    if (cur_state !== ST_DECODE || ir_ld !== 1'b0 || pc_up !== 1'b0 || nxt_state !== ST_NOOP) begin
      n_fail++;
      $display("[TB] FAIL decode: got state=%0d next=%0d ir_ld=%b pc_up=%b, expected 2/3/0/0",
               cur_state, nxt_state, ir_ld, pc_up);
    end
    step();
    n_checks++;
    if (cur_state !== ST_NOOP) begin
      n_fail++;
      $display("[TB] FAIL noop: got state=%0d, expected 3", cur_state);
    end
    step();
    n_checks++;
    if (cur_state !== ST_FETCH) begin
      n_fail++;
      $display("[TB] FAIL noop_to_fetch: got state=%0d, expected 1", cur_state);
    end
    step();
    reset = 1'b1;
    #1;
    n_checks++;
    if (cur_state !== ST_INIT || pc_clr !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL async_reset_mid_decode: got state=%0d pc_clr=%b, expected 0/1", cur_state, pc_clr);
    end
  endtask

  task automatic test_store();
    go_to_exec(16'h1A53);
    n_checks++;
    if (cur_state !== ST_STORE || d_addr !== 8'h53 || d_wr !== 1'b1 || rf_ra_addr !== 4'hA || rf_w_en !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL store: got state=%0d d_addr=%h d_wr=%b ra=%h w_en=%b, expected 4/53/1/a/0",
               cur_state, d_addr, d_wr, rf_ra_addr, rf_w_en);
    end
  endtask

  task automatic test_load();
    go_to_exec(16'h2A53);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (cur_state !== ST_LOADA || d_addr !== 8'hA5 || rf_w_addr !== 4'h3 || rf_s !== 1'b1 || rf_w_en !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL loada_cycle%0d: got state=%0d d_addr=%h w_addr=%h rf_s=%b w_en=%b, expected 5/a5/3/1/0",
                 i, cur_state, d_addr, rf_w_addr, rf_s, rf_w_en);
      end
      step();
    end
    n_checks++;
    if (cur_state !== ST_LOADB || d_addr !== 8'hA5 || rf_w_addr !== 4'h3 || rf_s !== 1'b1 || rf_w_en !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL loadb: got state=%0d d_addr=%h w_addr=%h rf_s=%b w_en=%b, expected 6/a5/3/1/1",
               cur_state, d_addr, rf_w_addr, rf_s, rf_w_en);
    end
    step();
    n_checks++;
    if (cur_state !== ST_FETCH) begin
      n_fail++;
      $display("[TB] FAIL load_to_fetch: got state=%0d, expected 1", cur_state);
    end
    // A reset in the middle of a load must abandon it without a register write.
    go_to_exec(16'h2A53);
    reset = 1'b1;
    #1;
    n_checks++;
    if (cur_state !== ST_INIT || rf_w_en !== 1'b0 || d_addr !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_load: got state=%0d w_en=%b d_addr=%h, expected 0/0/00", cur_state, rf_w_en, d_addr);
    end
  endtask

  task automatic test_alu();
    go_to_exec(16'h3124);
    n_checks++;
    if (cur_state !== ST_ALU || rf_ra_addr !== 4'h1 || rf_rb_addr !== 4'h2 || rf_w_addr !== 4'h4 ||
        alu_s0 !== 3'd1 || rf_w_en !== 1'b1 || rf_s !== 1'b0 || d_addr !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL alu_add: got state=%0d ra=%h rb=%h w=%h alu=%0d w_en=%b rf_s=%b d_addr=%h, expected 7/1/2/4/1/1/0/00",
               cur_state, rf_ra_addr, rf_rb_addr, rf_w_addr, alu_s0, rf_w_en, rf_s, d_addr);
    end
    go_to_exec(16'h4124);
    n_checks++;
    if (cur_state !== ST_ALU || rf_ra_addr !== 4'h1 || rf_rb_addr !== 4'h2 || rf_w_addr !== 4'h4 ||
        alu_s0 !== 3'd2 || rf_w_en !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL alu_sub: got state=%0d ra=%h rb=%h w=%h alu=%0d w_en=%b, expected 7/1/2/4/2/1",
               cur_state, rf_ra_addr, rf_rb_addr, rf_w_addr, alu_s0, rf_w_en);
    end
  endtask

  task automatic test_jumps();
    zero = 1'b0;
    go_to_exec(16'h7040);
    n_checks++;
    if (cur_state !== ST_JZ || pc_ld !== 1'b0 || pc_addr !== 8'h40) begin
      n_fail++;
      $display("[TB] FAIL jz_not_taken: got state=%0d pc_ld=%b pc_addr=%h, expected 9/0/40", cur_state, pc_ld, pc_addr);
    end
    zero = 1'b1;
    #1;
    n_checks++;
    if (pc_ld !== 1'b1 || pc_addr !== 8'h40 || pc_up !== 1'b0 || pc_clr !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL jz_taken: got pc_ld=%b pc_addr=%h pc_up=%b pc_clr=%b, expected 1/40/0/0", pc_ld, pc_addr, pc_up, pc_clr);
    end
    step();
    zero = 1'b0;
    n_checks++;
    if (cur_state !== ST_FETCH) begin
      n_fail++;
      $display("[TB] FAIL jz_to_fetch: got state=%0d, expected 1", cur_state);
    end
    go_to_exec(16'h6033);
    n_checks++;
    if (cur_state !== ST_JMP || pc_ld !== 1'b1 || pc_addr !== 8'h33) begin
      n_fail++;
      $display("[TB] FAIL jmp: got state=%0d pc_ld=%b pc_addr=%h, expected 8/1/33", cur_state, pc_ld, pc_addr);
    end
  endtask

  task automatic test_halt_run();
    go_to_exec(16'h5000);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (cur_state !== ST_HALT || halted !== 1'b1 || illegal !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL halt_hold%0d: got state=%0d halted=%b illegal=%b, expected 10/1/0", i, cur_state, halted, illegal);
      end
      step();
    end
    run = 1'b1;
    step();
    run = 1'b0;
    n_checks++;
    if (cur_state !== ST_FETCH || halted !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL halt_resume: got state=%0d halted=%b, expected 1/0", cur_state, halted);
    end
    // Run held high outside Halt must not divert the sequence.
    ir = 16'h3124;
    step();
    run = 1'b1;
    step();
    n_checks++;
    if (cur_state !== ST_ALU) begin
      n_fail++;
      $display("[TB] FAIL run_ignored_decode: got state=%0d, expected 7", cur_state);
    end
    step();
    run = 1'b0;
    n_checks++;
    if (cur_state !== ST_FETCH) begin
      n_fail++;
      $display("[TB] FAIL run_ignored_alu: got state=%0d, expected 1", cur_state);
    end
  endtask

  task automatic test_illegal();
    go_to_exec(16'hF000);
    n_checks++;
    if (cur_state !== ST_HALT || illegal !== 1'b1 || halted !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL illegal_detect: got state=%0d illegal=%b halted=%b, expected 10/1/1", cur_state, illegal, halted);
    end
    run = 1'b1;
    step();
    run = 1'b0;
    n_checks++;
    if (cur_state !== ST_FETCH || illegal !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL illegal_sticky: got state=%0d illegal=%b, expected 1/1", cur_state, illegal);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (illegal !== 1'b0 || cur_state !== ST_INIT) begin
      n_fail++;
      $display("[TB] FAIL illegal_clear: got illegal=%b state=%0d, expected 0/0", illegal, cur_state);
    end
    step();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_alu();
    test_jumps();
    test_halt_run();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
